uart_bus_sequencer: RTL and testbench

//  Command sequencer behind the UART receiver. Parses ASCII tokens ('A','W','R','E', hex digits
//  0-9/a-f), runs one single-beat bus transaction per command on a simple req/ack master port,

---
 rtl/uart_bus_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_uart_bus_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_sequencer.sv
// ASCII command sequencer: parses A/W/R/E + hex tokens from the UART receiver, runs one
// single-beat req/ack bus transaction per command and streams the ASCII reply to the transmitter.
module uart_bus_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_INC       = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_stb,
  output logic        o_bus_cyc,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_stb,
  input  logic        i_tx_busy,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_BUS, S_RESP} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_A, CMD_W, CMD_R} cmd_t;
  typedef enum logic [1:0] {RESP_K, RESP_X, RESP_R} resp_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next_state;
  cmd_t        r_cmd, w_tok_cmd;
  resp_t       r_resp_kind;
  logic [31:0] r_value, r_bus_addr, r_bus_wdata, r_rdata;
  logic [3:0]  r_count, r_resp_idx;
  logic [15:0] r_tmo;
  logic        r_is_write, r_tx_stb;
  logic [7:0]  r_tx_data;

  logic [6:0]  w_tok;
  logic        w_unused;
  logic        w_is_hex, w_is_cmd, w_is_e;
  logic [3:0]  w_nibble, w_resp_nib, w_resp_len;
  logic        w_accept, w_end, w_end_bus, w_end_resp, w_ack, w_tmo, w_issue;
  logic [7:0]  w_resp_byte;

  assign w_tok    = i_rx_data[6:0];
  assign w_unused = i_rx_data[7];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_is_hex  = 1'b0;
    w_nibble  = 4'd0;
    w_is_cmd  = 1'b1;
    w_tok_cmd = CMD_NONE;
    if (w_tok >= 7'h30 && w_tok <= 7'h39) begin
      w_is_hex = 1'b1;
      w_nibble = w_tok[3:0];
    end else if (w_tok >= 7'h61 && w_tok <= 7'h66) begin
      w_is_hex = 1'b1;
      w_nibble = w_tok[3:0] + 4'd9;
    end
    case (w_tok)
      7'h41:   w_tok_cmd = CMD_A;
      7'h57:   w_tok_cmd = CMD_W;
      7'h52:   w_tok_cmd = CMD_R;
      default: w_is_cmd  = 1'b0;
    endcase
  end

  assign w_is_e     = (w_tok == 7'h45);
  assign w_accept   = i_rx_stb && (r_state == S_IDLE || r_state == S_COLLECT);
  assign w_end      = w_accept && w_is_e && (r_state == S_COLLECT);
  assign w_end_bus  = w_end && (r_cmd == CMD_R || (r_cmd == CMD_W && r_count != 4'd0));
  assign w_end_resp = w_end && !w_end_bus;
  assign w_ack      = (r_state == S_BUS) && i_bus_ack;
  // Ack on the final timeout cycle takes priority over the abort.
  assign w_tmo      = (r_state == S_BUS) && !i_bus_ack && (r_tmo == TMO_LAST);
  assign w_resp_len = (r_resp_kind == RESP_R) ? 4'd10 : 4'd2;
  assign w_issue    = (r_state == S_RESP) && !r_tx_stb && !i_tx_busy && (r_resp_idx != w_resp_len);
  assign w_resp_nib = 4'(r_rdata >> {4'd8 - r_resp_idx, 2'b00});

  always_comb begin
    w_resp_byte = 8'h0A;
    if (r_resp_idx == 4'd0) begin
      case (r_resp_kind)
        RESP_K:  w_resp_byte = 8'h4B;
        RESP_R:  w_resp_byte = 8'h52;
        default: w_resp_byte = 8'h58;
      endcase
    end else if (r_resp_idx != w_resp_len - 4'd1) begin
      w_resp_byte = (w_resp_nib < 4'd10) ? {4'h3, w_resp_nib} : 8'h57 + {4'h0, w_resp_nib};
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && w_is_cmd) w_next_state = S_COLLECT;
      S_COLLECT: begin
        if (w_end_bus)       w_next_state = S_BUS;
        else if (w_end_resp) w_next_state = S_RESP;
      end
      S_BUS:     if (w_ack || w_tmo) w_next_state = S_RESP;
      S_RESP:    if (r_tx_stb && r_resp_idx == w_resp_len) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    o_bus_cyc   = (r_state == S_BUS);
    o_bus_we    = (r_state == S_BUS) && r_is_write;
    o_busy      = (r_state == S_BUS) || (r_state == S_RESP);
    o_bus_addr  = r_bus_addr;
    o_bus_wdata = r_bus_wdata;
    o_tx_data   = r_tx_data;
    o_tx_stb    = r_tx_stb;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cmd       <= CMD_NONE;
      r_value     <= 32'd0;
      r_count     <= 4'd0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_rdata     <= 32'd0;
      r_is_write  <= 1'b0;
      r_tmo       <= 16'd0;
      r_resp_kind <= RESP_K;
      r_resp_idx  <= 4'd0;
      r_tx_stb    <= 1'b0;
      r_tx_data   <= 8'd0;
    end else begin
      if (w_accept && w_is_cmd) begin
        r_cmd   <= w_tok_cmd;
        r_value <= 32'd0;
        r_count <= 4'd0;
      end else if (w_accept && w_is_hex && r_state == S_COLLECT) begin
        r_value <= {r_value[27:0], w_nibble};
        if (r_count != 4'd8) r_count <= r_count + 4'd1;
      end else if (w_end) begin
        r_cmd       <= CMD_NONE;
        r_tmo       <= 16'd0;
        r_resp_idx  <= 4'd0;
        r_is_write  <= (r_cmd == CMD_W);
        r_resp_kind <= RESP_X;
        if (r_cmd == CMD_A && r_count != 4'd0) begin
          r_bus_addr  <= r_value;
          r_resp_kind <= RESP_K;
        end
        if (r_cmd == CMD_W && r_count != 4'd0) r_bus_wdata <= r_value;
      end

      if (r_state == S_BUS) begin
        r_tmo <= r_tmo + 16'd1;
        if (i_bus_ack) begin
          if (!r_is_write) r_rdata <= i_bus_rdata;
          if (AUTO_INC)    r_bus_addr <= r_bus_addr + 32'd1;
          r_resp_kind <= r_is_write ? RESP_K : RESP_R;
        end else if (w_tmo) begin
          r_resp_kind <= RESP_X;
        end
      end

      r_tx_stb <= w_issue;
      if (w_issue) begin
        r_tx_data  <= w_resp_byte;
        r_resp_idx <= r_resp_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Directed self-checking bench for uart_bus_sequencer: command parsing, bus handshakes,
// timeout, transmitter back-pressure, ignored tokens and mid-transaction reset.
module tb_uart_bus_sequencer;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_rx_data = 8'd0;
  logic        i_rx_stb = 1'b0;
  logic        o_bus_cyc, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic        i_bus_ack = 1'b0;
  logic [31:0] i_bus_rdata = 32'd0;
  logic [7:0]  o_tx_data;
  logic        o_tx_stb;
  logic        i_tx_busy = 1'b0;
  logic        o_busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic prev_stb = 1'b0;
  int dbl_stb = 0;

  uart_bus_sequencer #(.TIMEOUT_CYCLES(255), .AUTO_INC(1'b1)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_stb(i_rx_stb),
    .o_bus_cyc(o_bus_cyc), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
    .o_tx_data(o_tx_data), .o_tx_stb(o_tx_stb),
    .i_tx_busy(i_tx_busy), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Transmitter side: capture each strobed byte, note back-to-back strobes.
  always @(negedge clk) begin
    if (o_tx_stb) q.push_back(o_tx_data);
    if (o_tx_stb && prev_stb) dbl_stb++;
    prev_stb = o_tx_stb;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input string exp);
    bit ok;
    ok = (q.size() == exp.len());
    for (int i = 0; i < q.size() && i < exp.len(); i++)
      if (q[i] != exp[i]) ok = 1'b0;
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL %s: observed %0d bytes (first %h) expected %0d bytes (first %h)",
             tag, q.size(), (q.size() > 0) ? q[0] : 8'h00, exp.len(), exp[0]);
    end
    q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_stb  = 1'b1;
    tick();
    i_rx_stb  = 1'b0;
    i_rx_data = 8'd0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic bus_ack(input int delay, input logic [31:0] rdata);
    repeat (delay) tick();
    i_bus_rdata = rdata;
    i_bus_ack   = 1'b1;
    tick();
    i_bus_ack   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((o_busy || o_tx_stb) && n < 2000) begin
      tick();
      n++;
    end
    check({tag, " reaches idle"}, 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int k);
    int n = 0;
    while (q.size() < k && n < 200) begin
      tick();
      n++;
    end
    check({tag, " bytes arrive"}, 32'(q.size() >= k), 32'd1);
  endtask

  initial begin
    int n;
    int n0;

    // Reset values.
    repeat (3) tick();
    check("rst cyc", o_bus_cyc, 0);
    check("rst we", o_bus_we, 0);
    check("rst busy", o_busy, 0);
    check("rst stb", o_tx_stb, 0);
    check("rst addr", o_bus_addr, 0);
    check("rst wdata", o_bus_wdata, 0);
    check("rst txdata", o_tx_data, 0);
    i_reset = 1'b0;
    tick();

    // 1: set address, then write with a late ack.
    send_str("A10E");
    wait_idle("t1a");
    check_resp("t1a resp", "K\n");
    check("t1 addr", o_bus_addr, 32'h10);
    send_str("W00abcdefE");
    check("t1 cyc", o_bus_cyc, 1);
    check("t1 we", o_bus_we, 1);
    check("t1 wdata", o_bus_wdata, 32'h00ABCDEF);
    check("t1 busy", o_busy, 1);
    bus_ack(3, 32'h0);
    check("t1 cyc drop", o_bus_cyc, 0);
    wait_idle("t1w");
    check_resp("t1w resp", "K\n");
    check("t1 addr inc", o_bus_addr, 32'h11);

    // 2: read; bytes sent while busy are dropped.
    send_str("A20E");
    wait_idle("t2a");
    check_resp("t2a resp", "K\n");
    send_str("RE");
    check("t2 we", o_bus_we, 0);
    send_str("A55E");
    bus_ack(0, 32'hDEADBEEF);
    wait_idle("t2r");
    check_resp("t2r resp", "Rdeadbeef\n");
    check("t2 addr", o_bus_addr, 32'h21);

    // 3: read with no ack times out after 255 cycles.
    send_str("RE");
    n = 0;
    while (o_bus_cyc && n < 1000) begin
      n++;
      tick();
    end
    check("t3 cyc cycles", n, 255);
    wait_idle("t3");
    check_resp("t3 resp", "X\n");
    check("t3 addr", o_bus_addr, 32'h21);

    // 4: transmitter busy for 50 cycles in the middle of a read reply.
    send_str("RE");
    bus_ack(1, 32'h0123ABCD);
    wait_bytes("t4", 3);
    i_tx_busy = 1'b1;
    @(negedge clk);
    n0 = q.size();
    repeat (50) tick();
    @(negedge clk);
    check("t4 no stb while busy", q.size(), n0);
    #1;
    i_tx_busy = 1'b0;
    wait_idle("t4");
    check_resp("t4 resp", "R0123abcd\n");
    check("t4 addr", o_bus_addr, 32'h22);

    // 5: ignored tokens, digit overflow, empty argument.
    send_str("Z 5");
    check("t5 idle busy", o_busy, 0);
    check("t5 idle addr", o_bus_addr, 32'h22);
    send_str("A123456789E");
    wait_idle("t5a");
    check_resp("t5a resp", "K\n");
    check("t5 addr", o_bus_addr, 32'h23456789);
    send_str("AE");
    wait_idle("t5b");
    check_resp("t5b resp", "X\n");
    check("t5 addr kept", o_bus_addr, 32'h23456789);
    send_str("WE");
    check("t5 we no cyc", o_bus_cyc, 0);
    wait_idle("t5c");
    check_resp("t5c resp", "X\n");
    check("t5 wdata kept", o_bus_wdata, 32'h00ABCDEF);

    // 6: reset during bus cycle and mid-response.
    send_str("RE");
    repeat (5) tick();
    i_reset = 1'b1;
    tick();
    check("t6 bus cyc", o_bus_cyc, 0);
    check("t6 bus busy", o_busy, 0);
    check("t6 bus addr", o_bus_addr, 0);
    check("t6 bus wdata", o_bus_wdata, 0);
    i_reset = 1'b0;
    tick();
    send_str("A7E");
    wait_idle("t6a");
    check_resp("t6a resp", "K\n");
    send_str("RE");
    bus_ack(0, 32'h11112222);
    wait_bytes("t6", 2);
    i_reset = 1'b1;
    tick();
    check("t6 resp stb", o_tx_stb, 0);
    check("t6 resp txdata", o_tx_data, 0);
    check("t6 resp busy", o_busy, 0);
    check("t6 resp addr", o_bus_addr, 0);
    i_reset = 1'b0;
    tick();
    q.delete();
    send_str("RE");
    bus_ack(2, 32'hCAFEF00D);
    wait_idle("t6r");
    check_resp("t6r resp", "Rcafef00d\n");
    check("t6 addr", o_bus_addr, 32'h1);

    check("no back-to-back stb", dbl_stb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
